// File: rtl/puf_challenge_sequencer_if.sv
// puf_challenge_sequencer_if: valid/ready stream carrying captured
// (challenge, response, timeout) pairs from the sequencer to a consumer.
interface puf_challenge_sequencer_if #(
  parameter int CHALL_W = 8,
  parameter int RESP_W  = 8
);
  logic               valid;
  logic               ready;
  logic [CHALL_W-1:0] chall;
  logic [RESP_W-1:0]  resp;
  logic               timeout;

  modport master (
    output valid,
    output chall,
    output resp,
    output timeout,
    input  ready
  );

  modport slave (
    input  valid,
    input  chall,
    input  resp,
    input  timeout,
    output ready
  );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer: sweeps every PUF challenge, streams the pairs.
// Define PUF_SEQ_HAMMING_EN to add hd_sum_o (inter-response Hamming sum).
module puf_challenge_sequencer #(
  parameter int CHALL_W     = 8,
  parameter int RESP_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               puf_rst_o,
  output logic               puf_en_o,
  output logic [CHALL_W-1:0] puf_chall_o,
  input  logic [RESP_W-1:0]  puf_response_i,
  input  logic               puf_ready_i,
  puf_challenge_sequencer_if.master out_if,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        ones_count_o,
  output logic [15:0]        timeout_cnt_o
`ifdef PUF_SEQ_HAMMING_EN
  ,
  output logic [15:0]        hd_sum_o
`endif
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_OUTPUT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CHALL_W-1:0] cnt_q, cnt_d;
  logic [15:0]        wait_q, wait_d;
  logic               to_q, to_d;
  logic               valid_q, valid_d;
  logic [CHALL_W-1:0] chall_q, chall_d;
  logic [RESP_W-1:0]  resp_q, resp_d;
  logic               tout_q, tout_d;
  logic [15:0]        ones_q, ones_d;
  logic [15:0]        tcnt_q, tcnt_d;
`ifdef PUF_SEQ_HAMMING_EN
  logic [RESP_W-1:0]  prev_q, prev_d;
  logic               have_prev_q, have_prev_d;
  logic [15:0]        hd_q, hd_d;
`endif

  logic accept;

  function automatic logic [15:0] popcnt(input logic [RESP_W-1:0] v);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < RESP_W; i++) begin
      n = n + 16'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [15:0] sat_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign accept = valid_q && out_if.ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    to_d    = to_q;
    valid_d = valid_q;
    chall_d = chall_q;
    resp_d  = resp_q;
    tout_d  = tout_q;
    ones_d  = ones_q;
    tcnt_d  = tcnt_q;
`ifdef PUF_SEQ_HAMMING_EN
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    hd_d        = hd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          ones_d  = '0;
          tcnt_d  = '0;
`ifdef PUF_SEQ_HAMMING_EN
          hd_d        = '0;
          have_prev_d = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = '0;
        to_d    = 1'b0;
      end
      S_WAIT: begin
        // wait_q == 0 marks the first cycle, where ready may be stale
        if (wait_q != 16'd0 && puf_ready_i) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q + 16'd1;
          if (wait_q + 16'd1 == TO_LIM) begin
            state_d = S_CAPTURE;
            to_d    = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        chall_d = cnt_q;
        resp_d  = to_q ? '0 : puf_response_i;
        tout_d  = to_q;
        valid_d = 1'b1;
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (accept) begin
          valid_d = 1'b0;
          ones_d  = sat_add(ones_q, popcnt(resp_q));
          tcnt_d  = sat_add(tcnt_q, 16'(tout_q));
`ifdef PUF_SEQ_HAMMING_EN
          if (!tout_q) begin
            if (have_prev_q) begin
              hd_d = sat_add(hd_q, popcnt(resp_q ^ prev_q));
            end
            prev_d      = resp_q;
            have_prev_d = 1'b1;
          end
`endif
          if (cnt_q == '1) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      to_q    <= 1'b0;
      valid_q <= 1'b0;
      chall_q <= '0;
      resp_q  <= '0;
      tout_q  <= 1'b0;
      ones_q  <= '0;
      tcnt_q  <= '0;
`ifdef PUF_SEQ_HAMMING_EN
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      hd_q        <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      chall_q <= chall_d;
      resp_q  <= resp_d;
      tout_q  <= tout_d;
      ones_q  <= ones_d;
      tcnt_q  <= tcnt_d;
`ifdef PUF_SEQ_HAMMING_EN
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      hd_q        <= hd_d;
`endif
    end
  end

  assign puf_rst_o     = (state_q == S_ISSUE);
  assign puf_en_o      = (state_q == S_WAIT);
  assign puf_chall_o   = cnt_q;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o        = (state_q == S_DONE);
  assign ones_count_o  = ones_q;
  assign timeout_cnt_o = tcnt_q;
  assign out_if.valid   = valid_q;
  assign out_if.chall   = chall_q;
  assign out_if.resp    = resp_q;
  assign out_if.timeout = tout_q;
`ifdef PUF_SEQ_HAMMING_EN
  assign hd_sum_o = hd_q;
`endif

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb_puf_challenge_sequencer: PUF model plus scoreboard of expected pairs,
// covering backpressure, stuck ready, timeout and mid-sweep reset.
`timescale 1ns/1ps
module tb_puf_challenge_sequencer;
  localparam int CW = 8;
  localparam int RW = 8;
  localparam int TO = 16;
  localparam int N  = 256;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] r;
    logic       t;
    logic [7:0] en;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        puf_rst, puf_en, puf_ready;
  logic [7:0]  puf_chall, puf_resp;
  logic        busy, done;
  logic [15:0] ones, tcnt;
`ifdef PUF_SEQ_HAMMING_EN
  logic [15:0] hd;
`endif

  logic       stuck = 1'b0;
  logic       blk5 = 1'b0;
  logic       inv = 1'b1;
  logic       bp = 1'b0;
  logic [1:0] dly;
  logic [1:0] ph = 2'd0;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [7:0] exp_idx = 8'd0;
  int   exp_ones = 0;
  int   exp_to = 0;
  int   npairs = 0;
  int   done_cnt = 0;
  int   en_cyc = 0;
  logic held_v = 1'b0;
  logic [7:0] held_c, held_r;

  puf_challenge_sequencer_if #(.CHALL_W(CW), .RESP_W(RW)) oif();

  puf_challenge_sequencer #(
    .CHALL_W(CW),
    .RESP_W(RW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .puf_rst_o(puf_rst),
    .puf_en_o(puf_en),
    .puf_chall_o(puf_chall),
    .puf_response_i(puf_resp),
    .puf_ready_i(puf_ready),
    .out_if(oif),
    .busy_o(busy),
    .done_o(done),
    .ones_count_o(ones),
    .timeout_cnt_o(tcnt)
`ifdef PUF_SEQ_HAMMING_EN
    ,
    .hd_sum_o(hd)
`endif
  );

  always #5 clk = ~clk;

  // PUF model: ready from the third WAIT cycle, never for 05 when blk5
  always @(posedge clk) begin
    if (rst) dly <= 2'd0;
    else if (puf_rst) dly <= 2'd1;
    else if (dly != 2'd0 && dly != 2'd3) dly <= dly + 2'd1;
  end
  assign puf_ready = stuck |
    (dly == 2'd3 && puf_en && !(blk5 && puf_chall == 8'h05));
  assign puf_resp = inv ? ~puf_chall : puf_chall;

  always @(negedge clk) begin
    ph = ph + 2'd1;
    oif.ready = bp ? (ph == 2'd0) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (puf_rst) begin
        chk("issue_chall", 64'(puf_chall), 64'(exp_idx));
        e.c  = exp_idx;
        e.t  = blk5 && !stuck && exp_idx == 8'h05;
        e.r  = e.t ? 8'h00 : (inv ? ~exp_idx : exp_idx);
        e.en = stuck ? 8'd2 : (e.t ? 8'(TO) : 8'd3);
        exp_q.push_back(e);
        exp_idx = exp_idx + 8'd1;
        en_cyc = 0;
      end
      if (puf_en) en_cyc++;
      if (done) done_cnt++;
      if (oif.valid) begin
        if (held_v) begin
          chk("hold_chall", 64'(oif.chall), 64'(held_c));
          chk("hold_resp", 64'(oif.resp), 64'(held_r));
        end
        if (oif.ready) begin
          chk("pair_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pair_chall", 64'(oif.chall), 64'(e.c));
            chk("pair_resp", 64'(oif.resp), 64'(e.r));
            chk("pair_timeout", 64'(oif.timeout), 64'(e.t));
            chk("wait_cycles", 64'(en_cyc), 64'(e.en));
            exp_ones += $countones(e.r);
            exp_to += int'(e.t);
            npairs++;
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_c = oif.chall;
          held_r = oif.resp;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic clear_sb();
    exp_idx  = 8'd0;
    exp_ones = 0;
    exp_to   = 0;
    npairs   = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {busy, done, puf_rst, puf_en, puf_chall, oif.valid,
              oif.chall, oif.resp, oif.timeout, ones, tcnt}, 64'd0);
  endtask

  task automatic run_sweep(input logic s, input logic b,
                           input logic i, input logic bpm);
    int cyc;
    stuck = s;
    blk5 = b;
    inv = i;
    bp = bpm;
    @(negedge clk);
    clear_sb();
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
    @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("done_low", 64'(done), 64'd0);
    chk("busy_low", 64'(busy), 64'd0);
    chk("pair_count", 64'(npairs), 64'(N));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("ones_count", 64'(ones), 64'(exp_ones));
    chk("timeout_cnt", 64'(tcnt), 64'(exp_to));
  endtask

  initial begin
    int cyc;
    oif.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    run_sweep(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ones_1024", 64'(ones), 64'd1024);
    run_sweep(1'b1, 1'b0, 1'b1, 1'b0);
    run_sweep(1'b0, 1'b1, 1'b1, 1'b0);
    chk("timeout_one", 64'(tcnt), 64'd1);
    run_sweep(1'b0, 1'b0, 1'b1, 1'b1);

    stuck = 1'b0;
    blk5 = 1'b0;
    bp = 1'b0;
    clear_sb();
    pulse_start();
    cyc = 0;
    while (!(puf_en && puf_chall == 8'h40) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_40", 64'(puf_en && puf_chall == 8'h40), 64'd1);
    chk("ones_nonzero", 64'(ones != 16'd0), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("midsweep_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 64'(busy | oif.valid), 64'd0);
    run_sweep(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef PUF_SEQ_HAMMING_EN
    run_sweep(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hd_sum", 64'(hd), 64'd502);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
- Sits directly upstream of the ring-oscillator PUF core and drives its clk-domain control inputs.
- Sweeps every challenge 0..2^CHALL_W-1: resets the core, enables it, waits for its ready, captures the response.
- Streams each (challenge, response) pair out over a valid/ready handshake.
- Accumulates a ones-count of all responses for uniformity checking.

Parameters:
- CHALL_W, 8, challenge width; sweep length is 2^CHALL_W.
- RESP_W, 8, response width.
- TIMEOUT_CYC, 4096, maximum WAIT cycles per challenge before declaring a timeout; must be 1..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep; sampled only in IDLE.
- puf_rst  out  1  one-cycle reset pulse to the PUF core per challenge.
- puf_en  out  1  PUF enable.
- puf_chall  out  CHALL_W  challenge presented to the PUF.
- puf_response  in  RESP_W  PUF response.
- puf_ready  in  1  PUF response valid.
- out_valid  out  1  captured pair available.
- out_ready  in  1  consumer accepts the pair.
- out_chall  out  CHALL_W  challenge of the current pair.
- out_resp  out  RESP_W  response of the current pair (0 on timeout).
- out_timeout  out  1  current pair timed out.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last pair is accepted.
- ones_count  out  16  running sum of set bits over all accepted responses.
- timeout_cnt  out  16  number of timed-out challenges in the sweep.

Behaviour:
- Reset: the following are all 0, state IDLE, challenge counter 0:
  - puf_rst, puf_en, puf_chall
  - out_valid, out_chall, out_resp, out_timeout
  - busy, done, ones_count, timeout_cnt
- rst overrides everything, including mid-sweep; no pair is emitted or counted afterward.
- IDLE:
  - start=1 -> ISSUE.
  - ones_count and timeout_cnt clear to 0 on the same edge.
  - busy=1 from ISSUE until DONE; busy is 0 in IDLE and in DONE.
- ISSUE (1 cycle):
  - puf_rst=1, puf_en=0, puf_chall=counter.
  - -> WAIT; the wait counter clears to 0.
- WAIT:
  - puf_en=1, puf_rst=0, puf_chall held.
  - puf_ready is ignored in the first WAIT cycle (stale-ready guard).
  - From the second cycle, puf_ready=1 -> CAPTURE.
  - Otherwise the wait counter increments; reaching TIMEOUT_CYC -> CAPTURE with the timeout flag set.
- CAPTURE (1 cycle):
  - out_chall<=counter.
  - out_resp<=puf_response, or 0 if timeout.
  - out_timeout<=flag, out_valid<=1.
  - puf_en<=0.
  - -> OUTPUT.
- OUTPUT:
  - out_valid held high; out_chall, out_resp and out_timeout are stable until the handshake.
  - On out_valid&out_ready: out_valid<=0.
  - ones_count += popcount(out_resp); timeout_cnt += out_timeout.
  - Counter = all-ones -> DONE; else counter+1 -> ISSUE.
- DONE (1 cycle): done=1, then -> IDLE.
- Arithmetic:
  - ones_count and timeout_cnt saturate at 16'hFFFF.
  - Defaults cannot reach saturation: max ones_count is 2048.
- start while busy is ignored; start held high in IDLE after DONE begins a new sweep.
- Counter wraps only via the DONE path; exactly 2^CHALL_W pairs are emitted per sweep.
- out_ready high while out_valid=0 has no effect.
- Minimum per-challenge latency: ISSUE + 2 WAIT + CAPTURE + 1 OUTPUT = 5 cycles.

Optional Feature:
- Macro: PUF_SEQ_HAMMING_EN.
- Defined:
  - Adds output hd_sum (16 bits, reset 0, cleared on start).
  - On each accepted pair after the first in a sweep, hd_sum += popcount(out_resp XOR previous accepted out_resp).
  - Timed-out pairs neither update the previous response nor add to hd_sum.
- Undefined:
  - Port hd_sum and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- PUF model returns response = ~challenge, ready 3 cycles after puf_rst; out_ready tied 1; start pulse.
  - Required: 256 pairs in order 0..255, each out_resp==~out_chall.
  - Required: ones_count==1024, timeout_cnt==0, single done pulse, busy low afterward.
- Same model with puf_ready stuck high.
  - Required: no capture in the first WAIT cycle; each pair is still taken on the second WAIT cycle, with correct values.
- Model never asserts ready for challenge 8'h05; TIMEOUT_CYC=16.
  - Required: pair 05 has out_resp=0 and out_timeout=1 after exactly 16 WAIT cycles.
  - Required: timeout_cnt==1; the sweep completes.
- out_ready toggles 1 cycle on, 3 off.
  - Required: out_chall and out_resp stable while out_valid=1 and not accepted; no pair lost or duplicated.
- rst asserted during WAIT of challenge 8'h40.
  - Required: next cycle all outputs 0 and state IDLE.
  - Required: a new start restarts from challenge 0 with counts cleared.
- With PUF_SEQ_HAMMING_EN defined, model response = challenge.
  - Required: hd_sum equals the sum over i=1..255 of popcount(i XOR (i-1)) = 502.
